instr_fetch_ctrl: RTL and testbench



---
 rtl/instr_fetch_ctrl_pkg.sv | 15 +
 rtl/instr_fetch_ctrl_fetch_line_buf.sv | 46 ++++
 rtl/instr_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM state encodings, default address width, beats per instruction.
// No logic, so no latency.
// No flow control, so no backpressure.
package instr_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int BEATS      = 4;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_line_buf.sv
// Last-fetch line: 4x8 assembly buffer, tag/valid register and miss comparator.
// Writes take effect on the next edge; miss and word are combinational reads of that state.
// No backpressure; the controller decides when to write.
module fetch_line_buf
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [1:0]      wr_idx,
    input  logic [7:0]      wr_dat,
    input  logic            clr,
    input  logic            tag_ld,
    input  logic            valid_set,
    input  logic [PC_W-1:0] pc,
    output logic            miss,
    output logic [31:0]     word
);

    logic [7:0]      bytes_q [BEATS];
    logic [PC_W-1:0] tag_q;
    logic            valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++) bytes_q[i] <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (clr) begin
                for (int i = 0; i < BEATS; i++) bytes_q[i] <= '0;
            end else if (wr_en) begin
                bytes_q[wr_idx] <= wr_dat;
            end
            if (tag_ld)    tag_q   <= pc;
            if (valid_set) valid_q <= 1'b1;
        end
    end

    // Full-width compare: PCs aliasing in the memory window are still distinct lines.
    assign miss = !valid_q || (pc != tag_q);
    assign word = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: 4 byte reads at PC assembled into one instruction; FETCH_ALIGN_CHK_EN adds a sticky misalignment fault.
// Hit: 0 stall cycles; miss: BUSYWAIT for 5 cycles plus one per memory wait cycle.
// Stalls the CPU with BUSYWAIT; holds each beat while mem_busywait is high.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [PC_W-1:0]   PC,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [7:0]        mem_readdata,
    input  logic              mem_busywait
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic              fetch_fault
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [1:0]        beat;
    logic              miss;
    logic [31:0]       word;
    logic              align_bad;

    logic busy, start, buf_wr, buf_clr, tag_ld, valid_set, inst_ld;

`ifdef FETCH_ALIGN_CHK_EN
    assign align_bad = (PC[1:0] != 2'b00);
`else
    assign align_bad = 1'b0;
`endif

    fetch_line_buf #(
        .PC_W (PC_W)
    ) u_line_buf (
        .clk       (CLK),
        .rst       (RESET),
        .wr_en     (buf_wr),
        .wr_idx    (beat),
        .wr_dat    (mem_readdata),
        .clr       (buf_clr),
        .tag_ld    (tag_ld),
        .valid_set (valid_set),
        .pc        (PC),
        .miss      (miss),
        .word      (word)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mem_read  = 1'b0;
        start     = 1'b0;
        buf_wr    = 1'b0;
        buf_clr   = 1'b0;
        tag_ld    = 1'b0;
        valid_set = 1'b0;
        inst_ld   = 1'b0;
        case (state)
            IDLE: begin
                if (miss) begin
                    busy   = 1'b1;
                    tag_ld = 1'b1;
                    // A misaligned PC skips memory entirely and completes as a zero word.
                    if (align_bad) begin
                        buf_clr   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        start     = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    buf_wr = 1'b1;
                    if (beat == 2'(BEATS - 1)) state_nxt = DONE;
                end
            end
            DONE: begin
                valid_set = 1'b1;
                inst_ld   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSYWAIT    = busy && !RESET;
    assign mem_address = base + {{(ADDR_W-2){1'b0}}, beat};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            base        <= '0;
            beat        <= '0;
            INSTRUCTION <= 32'h0;
        end else begin
            if (start) begin
                base <= PC[ADDR_W-1:0];
                beat <= '0;
            end else if (buf_wr && beat != 2'(BEATS - 1)) begin
                beat <= beat + 2'd1;
            end
            if (inst_ld) INSTRUCTION <= word;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        fetch_fault <= 1'b0;
        else if (buf_clr) fetch_fault <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: byte memory with configurable wait states, address scoreboard.
module tb_instr_fetch_ctrl;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;
    logic        mem_read;
    logic [9:0]  mem_address;
    logic [7:0]  mem_readdata;
    logic        mem_busywait;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fetch_fault;
    logic        exp_fault;
`endif

    logic [7:0]  mem [0:1023];
    logic [9:0]  exp_q [$];
    int          wait_cfg;
    int          wait_cnt;
    int          rd_beats;
    int          total;
    int          bad;

    instr_fetch_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .fetch_fault  (fetch_fault)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory responder: each beat is held busy for wait_cfg cycles, then completes.
    assign mem_readdata = mem[mem_address];
    assign mem_busywait = mem_read && (wait_cnt < wait_cfg);

    always @(posedge CLK or posedge RESET) begin
        if (RESET)         wait_cnt <= 0;
        else if (mem_read) wait_cnt <= (wait_cnt < wait_cfg) ? wait_cnt + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    function automatic logic [31:0] assemble(input logic [31:0] pc);
        logic [9:0] a;
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            a = 10'(pc + 32'(i));
            w[8*i +: 8] = mem[a];
        end
        return w;
    endfunction

    // Scoreboard: every completing beat must match the next expected address.
    always begin
        @(negedge CLK);
        #2;
        if (!RESET && mem_read && !mem_busywait) begin
            rd_beats++;
            chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("beat_addr", 32'(mem_address), 32'(exp_q.pop_front()));
        end
    end

    // Called right after a negedge; measures stall length and checks the result.
    task automatic fetch(input logic [31:0] pc, input int waits, input string nm);
        int          n;
        bit          flt;
        logic [31:0] exp_i;
        flt = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        flt = (pc[1:0] != 2'b00);
`endif
        wait_cfg = waits;
        if (!flt) for (int i = 0; i < 4; i++) exp_q.push_back(10'(pc + 32'(i)));
        exp_i = flt ? 32'h0 : assemble(pc);
        PC = pc;
        #1;
        n = 0;
        while (BUSYWAIT === 1'b1 && n < 200) begin
            n++;
            @(negedge CLK);
            #1;
        end
        chk({nm, "_busy_cycles"}, 32'(n), flt ? 32'd1 : 32'(1 + 4 * (waits + 1)));
        @(negedge CLK);
        #1;
        chk({nm, "_instr"}, INSTRUCTION, exp_i);
        chk({nm, "_beats_done"}, 32'(exp_q.size()), 32'd0);
`ifdef FETCH_ALIGN_CHK_EN
        if (flt) exp_fault = 1'b1;
        chk({nm, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
`endif
    endtask

    initial begin
        logic [31:0] held;
        int          beats0;
        total    = 0;
        bad      = 0;
        rd_beats = 0;
        wait_cfg = 0;
        RESET    = 1'b1;
        PC       = 32'd0;
`ifdef FETCH_ALIGN_CHK_EN
        exp_fault = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 255);
        mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h04; mem[3] = 8'h00;

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_instr", INSTRUCTION, 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", 32'(mem_address), 32'd0);
        chk("rst_busywait", 32'(BUSYWAIT), 32'd0);

        // First fetch straight out of reset.
        @(negedge CLK);
        RESET = 1'b0;
        fetch(32'd0, 0, "pc0");
        chk("pc0_value", INSTRUCTION, 32'h00040005);

        // Repeated PC hits the line buffer.
        held   = INSTRUCTION;
        beats0 = rd_beats;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            #1;
            chk("hit_busywait", 32'(BUSYWAIT), 32'd0);
            chk("hit_mem_read", 32'(mem_read), 32'd0);
        end
        chk("hit_no_beats", 32'(rd_beats), 32'(beats0));
        chk("hit_instr_stable", INSTRUCTION, held);

        @(negedge CLK);
        fetch(32'd4, 2, "pc4_wait2");
        @(negedge CLK);
        fetch(32'd1020, 0, "pc1020");
        @(negedge CLK);
        fetch(32'd1022, 0, "pc1022_wrap");

        // Reset during beat 2 of PC=8: beats 0 and 1 complete, beat 2 is abandoned.
        @(negedge CLK);
        wait_cfg = 0;
        exp_q.push_back(10'd8);
        exp_q.push_back(10'd9);
        PC = 32'd8;
        repeat (3) @(negedge CLK);
        #1;
        chk("midrst_beat2_addr", 32'(mem_address), 32'd10);
        chk("midrst_beat2_read", 32'(mem_read), 32'd1);
        RESET = 1'b1;
        #1;
        chk("midrst_mem_read", 32'(mem_read), 32'd0);
        chk("midrst_instr", INSTRUCTION, 32'h0);
        chk("midrst_busywait", 32'(BUSYWAIT), 32'd0);
        chk("midrst_beats_done", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_ALIGN_CHK_EN
        exp_fault = 1'b0;
`endif
        @(negedge CLK);
        RESET = 1'b0;
        fetch(32'd8, 0, "refetch8");

`ifdef FETCH_ALIGN_CHK_EN
        @(negedge CLK);
        beats0 = rd_beats;
        fetch(32'd6, 0, "misalign6");
        chk("misalign_no_beats", 32'(rd_beats), 32'(beats0));
        @(negedge CLK);
        fetch(32'd8, 0, "after_fault8");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
